// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, FSM states and load/store helper functions for lsu_sram_ctrl
package lsu_pkg;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   function automatic logic [3:0] byte_en(input logic [1:0] size);
      return size == SZ_BYTE ? 4'b0001 :
             size == SZ_HALF ? 4'b0011 :
             size == SZ_WORD ? 4'b1111 : 4'b0000;
   endfunction
   function automatic logic [31:0] load_ext(input logic [1:0] size, input logic uns, input logic [31:0] data);
      return size == SZ_BYTE ? {{24{~uns & data[7]}}, data[7:0]} :
             size == SZ_HALF ? {{16{~uns & data[15]}}, data[15:0]} : data;
   endfunction
endpackage

// File: rtl/lsu_sram_ctrl.sv
// lsu_sram_ctrl: one-at-a-time load/store controller in front of a byte-addressable SRAM
module lsu_sram_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 32,
   parameter bit CHECK_ALIGN = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [3:0]        mem_w_en,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic [DATA_W-1:0] mem_read_data
);
   state_t     state;
   logic       lat_we;
   logic [1:0] lat_size;
   logic       lat_uns;
   logic       bad;
   // illegal size, or (when checked) a half/word not on its natural boundary
   always_comb bad = req_size == SZ_ILL ||
                     (CHECK_ALIGN && ((req_size == SZ_HALF && req_addr[0]) ||
                                      (req_size == SZ_WORD && req_addr[1:0] != 2'b00)));
   // FSM with registered outputs; SRAM strobes are set on entry to ACCESS and dropped on exit,
   // and rsp_valid rises one cycle after entering RESP
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         req_ready      <= 1'b1;
         rsp_valid      <= 1'b0;
         rsp_err        <= 1'b0;
         rsp_rdata      <= '0;
         mem_w_en       <= 4'b0000;
         mem_address    <= '0;
         mem_write_data <= '0;
         lat_we         <= 1'b0;
         lat_size       <= SZ_BYTE;
         lat_uns        <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid && req_ready) begin
               lat_we    <= req_we;
               lat_size  <= req_size;
               lat_uns   <= req_unsigned;
               req_ready <= 1'b0;
               rsp_err   <= bad;
               if (bad) begin
                  state     <= RESP;
                  rsp_rdata <= '0;
               end else begin
                  state          <= ACCESS;
                  mem_address    <= req_addr;
                  mem_write_data <= req_wdata;
                  mem_w_en       <= req_we ? byte_en(req_size) : 4'b0000;
               end
            end
            ACCESS: begin
               state     <= RESP;
               mem_w_en  <= 4'b0000;
               rsp_rdata <= lat_we ? '0 : load_ext(lat_size, lat_uns, mem_read_data);
            end
            RESP: if (rsp_valid && rsp_ready) begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
            end else begin
               rsp_valid <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
